// File: rtl/store_buffer.sv
// Committed-store buffer: circular FIFO of retired stores drained in order toward the DCache
// write port, with combinational youngest-first store-to-load forwarding.
module store_buffer #(
  parameter  int unsigned DEPTH     = 8,
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 st_valid_i,
  output logic                 st_ready_o,
  input  logic [31:0]          st_addr_i,
  input  logic [31:0]          st_data_i,
  input  logic [3:0]           st_strb_i,
  output logic                 wr_valid_o,
  input  logic                 wr_ready_i,
  output logic [31:0]          wr_addr_o,
  output logic [31:0]          wr_data_o,
  output logic [3:0]           wr_strb_o,
  input  logic [31:0]          fwd_addr_i,
  output logic                 fwd_hit_o,
  output logic [3:0]           fwd_strb_o,
  output logic [31:0]          fwd_data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [29:0]          addr_q  [DEPTH];
  logic [31:0]          data_q  [DEPTH];
  logic [3:0]           strb_q  [DEPTH];
  logic [DEPTH-1:0]     valid_q;
  logic [PtrW-1:0]      head_q, tail_q;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic enq, deq;
  logic [PtrW-1:0] idx;

  // Word-offset bits are don't-care on both address inputs.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{st_addr_i[1:0], fwd_addr_i[1:0]};

  // Status and write-port payload straight from registered state.
  always_comb begin
    empty_o    = (count_q == '0);
    full_o     = (count_q == CNT_WIDTH'(DEPTH));
    st_ready_o = !full_o;
    count_o    = count_q;
    wr_valid_o = !empty_o;
    wr_addr_o  = {addr_q[head_q], 2'b00};
    wr_data_o  = data_q[head_q];
    wr_strb_o  = strb_q[head_q];
    enq        = st_valid_i && st_ready_o;
    deq        = wr_valid_o && wr_ready_i;
  end

  // Occupancy next-state; simultaneous enqueue and dequeue leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Forwarding: walk oldest to youngest from the head so younger matches overwrite older lanes,
  // which keeps priority correct across pointer wrap.
  always_comb begin
    fwd_strb_o = '0;
    fwd_data_o = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (valid_q[idx] && (addr_q[idx] == fwd_addr_i[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (strb_q[idx][b]) begin
            fwd_strb_o[b]        = 1'b1;
            fwd_data_o[8*b +: 8] = data_q[idx][8*b +: 8];
          end
        end
      end
    end
    fwd_hit_o = |fwd_strb_o;
  end

  // Pointers, count and entry storage.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        strb_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      // Enqueue never targets the head slot while a dequeue is possible (not full => tail != head
      // unless empty), so the two valid-bit updates cannot collide.
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
      end
      if (enq) begin
        addr_q[tail_q]  <= st_addr_i[31:2];
        data_q[tail_q]  <= st_data_i;
        strb_q[tail_q]  <= st_strb_i;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 8).
module tb_store_buffer;

  logic        clk, a_rst;
  logic        st_valid_i, st_ready_o;
  logic [31:0] st_addr_i, st_data_i;
  logic [3:0]  st_strb_i;
  logic        wr_valid_o, wr_ready_i;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [3:0]  wr_strb_o;
  logic [31:0] fwd_addr_i;
  logic        fwd_hit_o;
  logic [3:0]  fwd_strb_o;
  logic [31:0] fwd_data_o;
  logic        empty_o, full_o;
  logic [3:0]  count_o;

  int n_checks = 0;
  int n_errors = 0;

  store_buffer #(.DEPTH(8)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .st_valid_i (st_valid_i),
    .st_ready_o (st_ready_o),
    .st_addr_i  (st_addr_i),
    .st_data_i  (st_data_i),
    .st_strb_i  (st_strb_i),
    .wr_valid_o (wr_valid_o),
    .wr_ready_i (wr_ready_i),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .wr_strb_o  (wr_strb_o),
    .fwd_addr_i (fwd_addr_i),
    .fwd_hit_o  (fwd_hit_o),
    .fwd_strb_o (fwd_strb_o),
    .fwd_data_o (fwd_data_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .count_o    (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge; offers one store across the next posedge and returns at the next negedge.
  task automatic enq(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_valid_i = 1'b1;
    st_addr_i  = a;
    st_data_i  = d;
    st_strb_i  = s;
    @(negedge clk);
    st_valid_i = 1'b0;
  endtask

  initial begin
    a_rst      = 1'b1;
    st_valid_i = 1'b0;
    st_addr_i  = '0;
    st_data_i  = '0;
    st_strb_i  = '0;
    wr_ready_i = 1'b0;
    fwd_addr_i = 32'h0000_0100;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_ready", 32'(st_ready_o), 32'd1);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("rst_wr_addr", wr_addr_o, 32'h0);
    check("rst_wr_data", wr_data_o, 32'h0);
    check("rst_fwd_hit", 32'(fwd_hit_o), 32'd0);
    check("rst_fwd_data", fwd_data_o, 32'h0);
    a_rst = 1'b0;
    @(negedge clk);

    // Fill and drain
    for (int i = 0; i < 8; i++) enq(32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    check("fill_full", 32'(full_o), 32'd1);
    check("fill_ready", 32'(st_ready_o), 32'd0);
    check("fill_count", 32'(count_o), 32'd8);
    enq(32'h500, 32'h5555_5555, 4'hF);
    check("fill_9th_rejected", 32'(count_o), 32'd8);
    check("fill_head_addr", wr_addr_o, 32'h100);
    wr_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", 32'(wr_valid_o), 32'd1);
      check("drain_addr", wr_addr_o, 32'h100 + 32'(4 * i));
      check("drain_data", wr_data_o, 32'hA000_0000 + 32'(i));
      @(negedge clk);
    end
    wr_ready_i = 1'b0;
    check("drain_empty", 32'(empty_o), 32'd1);
    check("drain_wr_valid", 32'(wr_valid_o), 32'd0);

    // Forward merge
    enq(32'h200, 32'h1122_3344, 4'b1111);
    enq(32'h202, 32'hAABB_0000, 4'b1100);
    fwd_addr_i = 32'h201;
    #1;
    check("merge_hit", 32'(fwd_hit_o), 32'd1);
    check("merge_strb", 32'(fwd_strb_o), 32'hF);
    check("merge_data", fwd_data_o, 32'hAABB_3344);
    @(negedge clk);
    wr_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    wr_ready_i = 1'b0;
    check("merge_drained", 32'(empty_o), 32'd1);

    // Forward miss/partial
    enq(32'h300, 32'h0000_00EE, 4'b0001);
    fwd_addr_i = 32'h304;
    #1;
    check("miss_hit", 32'(fwd_hit_o), 32'd0);
    check("miss_data", fwd_data_o, 32'h0);
    fwd_addr_i = 32'h300;
    #1;
    check("partial_strb", 32'(fwd_strb_o), 32'h1);
    check("partial_data", fwd_data_o, 32'h0000_00EE);
    // Store being enqueued this cycle is invisible.
    st_valid_i = 1'b1;
    st_addr_i  = 32'h400;
    st_data_i  = 32'hFFFF_FFFF;
    st_strb_i  = 4'hF;
    fwd_addr_i = 32'h400;
    #1;
    check("enq_invisible", 32'(fwd_hit_o), 32'd0);
    @(negedge clk);
    st_valid_i = 1'b0;
    check("enq_visible_after", 32'(fwd_strb_o), 32'hF);
    // Entry being dequeued this cycle is still visible.
    wr_ready_i = 1'b1;
    fwd_addr_i = 32'h300;
    #1;
    check("deq_still_visible", fwd_data_o, 32'h0000_00EE);
    repeat (2) @(negedge clk);
    wr_ready_i = 1'b0;
    #1;
    check("deq_gone", 32'(fwd_hit_o), 32'd0);
    check("partial_drained", 32'(empty_o), 32'd1);

    // Simultaneous enqueue/dequeue (head starts at 4, wraps past 7)
    for (int i = 0; i < 4; i++) enq(32'h600 + 32'(4 * i), 32'h60 + 32'(i), 4'hF);
    check("sim_count_start", 32'(count_o), 32'd4);
    for (int k = 0; k < 10; k++) begin
      st_valid_i = 1'b1;
      st_addr_i  = 32'h600 + 32'(4 * (k + 4));
      st_data_i  = 32'h60 + 32'(k + 4);
      st_strb_i  = 4'hF;
      wr_ready_i = 1'b1;
      check("sim_addr", wr_addr_o, 32'h600 + 32'(4 * k));
      check("sim_count", 32'(count_o), 32'd4);
      @(negedge clk);
    end
    st_valid_i = 1'b0;
    check("sim_count_end", 32'(count_o), 32'd4);
    for (int k = 10; k < 14; k++) begin
      check("sim_tail_addr", wr_addr_o, 32'h600 + 32'(4 * k));
      check("sim_tail_data", wr_data_o, 32'h60 + 32'(k));
      @(negedge clk);
    end
    wr_ready_i = 1'b0;
    check("sim_empty", 32'(empty_o), 32'd1);

    // Backpressure stability
    enq(32'h700, 32'hDEAD_BEEF, 4'b0110);
    for (int i = 0; i < 5; i++) begin
      enq(32'h704 + 32'(4 * i), 32'h7000 + 32'(i), 4'hF);
      check("bp_addr", wr_addr_o, 32'h700);
      check("bp_data", wr_data_o, 32'hDEAD_BEEF);
      check("bp_strb", 32'(wr_strb_o), 32'h6);
    end
    wr_ready_i = 1'b1;
    @(negedge clk);
    wr_ready_i = 1'b0;
    check("bp_count_after", 32'(count_o), 32'd5);
    check("bp_next_head", wr_addr_o, 32'h704);

    // Reset mid-operation, between clock edges
    fwd_addr_i = 32'h704;
    #1;
    check("prerst_hit", 32'(fwd_hit_o), 32'd1);
    #1 a_rst = 1'b1;
    #1;
    check("midrst_wr_valid", 32'(wr_valid_o), 32'd0);
    check("midrst_count", 32'(count_o), 32'd0);
    check("midrst_fwd_hit", 32'(fwd_hit_o), 32'd0);
    #1 a_rst = 1'b0;
    @(negedge clk);
    wr_ready_i = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_no_write", 32'(wr_valid_o), 32'd0);
    wr_ready_i = 1'b0;
    enq(32'h800, 32'h1234_5678, 4'hF);
    check("postrst_valid", 32'(wr_valid_o), 32'd1);
    check("postrst_addr", wr_addr_o, 32'h800);
    check("postrst_data", wr_data_o, 32'h1234_5678);
    wr_ready_i = 1'b1;
    @(negedge clk);
    wr_ready_i = 1'b0;
    check("postrst_empty", 32'(empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Committed-store buffer sitting between the load/store unit's commit path and the DCache write port. It accepts retired stores into a circular FIFO and drains them in program order as word-granular, byte-masked writes toward DCache. It also offers a combinational store-to-load forwarding port so that younger loads observe buffered data before it reaches the cache.

## Interface
Parameters:
- `DEPTH`, 8, number of entries; power of two, ≥ 2.
- `CNT_WIDTH`, `$clog2(DEPTH+1)`, width of `count_o` (derived, not overridable).

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `a_rst`  in  1  reset; one clock, reset asynchronous and active-high.
- `st_valid_i`  in  1  commit path offers a store.
- `st_ready_o`  out  1  buffer can accept a store (`!full_o`).
- `st_addr_i`  in  32  store byte address; bits [1:0] are ignored.
- `st_data_i`  in  32  store data, lane-aligned.
- `st_strb_i`  in  4  byte enables.
- `wr_valid_o`  out  1  head entry presented to DCache.
- `wr_ready_i`  in  1  DCache accepts the write.
- `wr_addr_o`  out  32  `{head.addr[31:2], 2'b00}`.
- `wr_data_o`  out  32  head data.
- `wr_strb_o`  out  4  head byte enables.
- `fwd_addr_i`  in  32  load address to check; bits [1:0] are ignored.
- `fwd_hit_o`  out  1  at least one byte is forwarded.
- `fwd_strb_o`  out  4  bytes supplied by the buffer.
- `fwd_data_o`  out  32  forwarded bytes; lanes not covered are 0.
- `empty_o`  out  1  count == 0.
- `full_o`  out  1  count == DEPTH.
- `count_o`  out  CNT_WIDTH  number of occupied entries.

## Operation
- Storage: DEPTH entries of {addr[31:2], data[31:0], strb[3:0], valid}. Head and tail pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. A separate count register holds the occupancy.
- Enqueue: fires when `st_valid_i && st_ready_o`. The store is written at the tail, the tail advances, and the entry is marked valid.
- Dequeue: fires when `wr_valid_o && wr_ready_i`. The head entry is marked invalid, the head advances, and its contents are left stale.
- Simultaneous enqueue and dequeue: both take effect and the count is unchanged.
- Write-port payload: `wr_valid_o` equals `!empty_o`. `wr_*` is driven combinationally from the head entry. The payload is stable while `wr_valid_o && !wr_ready_i`.
- `st_ready_o = !full_o` depends on registered state only. When full, a same-cycle dequeue does not open a slot for the store offered in that cycle.
- A store with `st_strb_i == 0` is accepted and drained like any other.
- Forwarding (combinational):
  - Candidates are valid entries whose addr[31:2] equals `fwd_addr_i[31:2]`.
  - For each lane b, the youngest candidate (closest to the tail) with strb[b]=1 supplies byte b, and `fwd_strb_o[b]=1`.
  - `fwd_hit_o = |fwd_strb_o`.
  - A store being enqueued in the current cycle is not visible.
  - An entry being dequeued in the current cycle is still visible.
- Reset (asynchronous, while `a_rst`=1):
  - Pointers and count go to 0; all valid bits and all entry fields clear.
  - Outputs: `empty_o`=1, `full_o`=0, `st_ready_o`=1, `count_o`=0, `wr_valid_o`=0, `wr_addr_o`/`wr_data_o`/`wr_strb_o`=0, `fwd_*`=0.
  - A reset asserted mid-operation discards all buffered stores. No write is issued afterward.

## Timing
- Enqueue-to-write latency is 1 cycle: a store accepted at edge N is presented on `wr_*` in the cycle after edge N. There is no same-cycle bypass.
- Forwarding has zero latency: combinational from `fwd_addr_i` and the registered entries.
- `count_o`, `empty_o` and `full_o` update at the clock edge after the handshake.
- Sustained throughput is one store per cycle in each direction when `0 < count < DEPTH`.
- Pointer wrap: tail index DEPTH-1 advances to 0, and likewise for the head. Youngest-first priority for forwarding is computed relative to the head, so it holds across the wrap.

## Test plan
- **Fill and drain:** hold `wr_ready_i`=0 and enqueue 8 stores at addresses 0x100, 0x104, …, 0x11C.
  - Required: `full_o`=1, `st_ready_o`=0, `count_o`=8, and a 9th offered store is not accepted.
  - Then set `wr_ready_i`=1. Required: writes emerge in order 0x100 … 0x11C on consecutive cycles, followed by `empty_o`=1.
- **Forward merge:** enqueue (0x200, 0x11223344, strb 4'b1111), then (0x202, 0xAABB0000, strb 4'b1100). Query 0x201.
  - Required: `fwd_hit_o`=1, `fwd_strb_o`=4'b1111, `fwd_data_o`=0xAABB3344.
- **Forward miss/partial:** with only (0x300, 0x000000EE, strb 4'b0001) buffered:
  - Query 0x304. Required: `fwd_hit_o`=0, `fwd_data_o`=0.
  - Query 0x300. Required: `fwd_strb_o`=4'b0001, `fwd_data_o`=0x000000EE.
- **Simultaneous enqueue/dequeue:** at `count_o`=4, hold both handshakes for 10 cycles.
  - Required: `count_o` stays 4, and the pointers wrap past index 7 with FIFO order preserved.
- **Backpressure stability:** with `wr_ready_i`=0 for 5 cycles while enqueueing behind the head.
  - Required: `wr_addr_o`/`wr_data_o`/`wr_strb_o` remain unchanged throughout.
- **Reset mid-operation:** with 5 entries buffered, pulse `a_rst` asynchronously between clock edges.
  - Required: `wr_valid_o`=0, `count_o`=0 and `fwd_hit_o`=0 immediately.
  - After release, the first new store is the first write observed.
